// File: rtl/fp_norm_pkg.sv
// Shared types and the single-precision packing helper for the fixed-point to float normaliser.
package fp_norm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DETECT = 3'd1,
    SHIFT  = 3'd2,
    PACK   = 3'd3,
    OUT    = 3'd4
  } fp_state_e;

  localparam int SP_EXP_W   = 8;
  localparam int SP_MANT_W  = 23;
  localparam int SP_EXP_MAX = 255;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        ovf;
    logic        udf;
  } sp_result_t;

  // Zero takes priority over underflow; overflow saturates to a signed infinity.
  function automatic sp_result_t pack_sp(input logic sign, input logic zero,
                                         input logic signed [31:0] exp_val,
                                         input logic [SP_MANT_W-1:0] mant);
    sp_result_t res;
    res = '0;
    if (zero) begin
      res.data = {sign, 31'b0};
      res.zero = 1'b1;
    end else if (exp_val <= 0) begin
      res.data = {sign, 31'b0};
      res.udf  = 1'b1;
    end else if (exp_val >= SP_EXP_MAX) begin
      res.data = {sign, {SP_EXP_W{1'b1}}, {SP_MANT_W{1'b0}}};
      res.ovf  = 1'b1;
    end else begin
      res.data = {sign, exp_val[SP_EXP_W-1:0], mant};
    end
    return res;
  endfunction

endpackage

// File: rtl/lead_one_pos.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module lead_one_pos #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]         i_data,
  output logic [$clog2(DATA_W)-1:0] o_pos,
  output logic                      o_zero
);

  localparam int POS_W = $clog2(DATA_W);

  logic [POS_W-1:0] w_pos;

  // Ascending scan so the highest set bit is the last assignment to win.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i_data[i]) w_pos = POS_W'(i);
    end
  end

  assign o_pos  = w_pos;
  assign o_zero = ~|i_data;

endmodule

// File: rtl/fxp_to_fp_norm_ctrl.sv
// Sequencer turning an unsigned fixed-point magnitude plus sign into an IEEE-754 single.
// Define NORM_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fxp_to_fp_norm_ctrl
  import fp_norm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 24,
  parameter int SHIFT_STEP = 8,
  parameter int EXP_BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_mag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_udf
);

  localparam int POS_W = $clog2(DATA_W);
  localparam int E_W   = POS_W + 10;

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_DETECT = DETECT;
  localparam logic [2:0] S_SHIFT  = SHIFT;
  localparam logic [2:0] S_PACK   = PACK;
  localparam logic [2:0] S_OUT    = OUT;

  logic [2:0]        r_state;
  logic              r_sign;
  logic [DATA_W-1:0] r_mag;
  logic [POS_W-1:0]  r_pos;
  logic [POS_W-1:0]  r_rem;
  logic              r_zero;
  logic              r_out_valid;
  logic [31:0]       r_out_data;
  logic              r_out_zero;
  logic              r_out_ovf;
  logic              r_out_udf;

  logic [POS_W-1:0]     w_lead_pos;
  logic                 w_lead_zero;
  logic [POS_W-1:0]     w_rem;
  logic [POS_W-1:0]     w_shamt;
  logic signed [E_W-1:0] w_exp;
  logic signed [E_W-1:0] w_exp_fin;
  logic [SP_MANT_W-1:0] w_mant_raw;
  logic [SP_MANT_W-1:0] w_mant;
  sp_result_t           w_pack;

  lead_one_pos #(.DATA_W(DATA_W)) u_lead_one (
    .i_data (r_mag),
    .o_pos  (w_lead_pos),
    .o_zero (w_lead_zero)
  );

  assign w_rem   = POS_W'(DATA_W - 1) - w_lead_pos;
  assign w_shamt = (r_rem > POS_W'(SHIFT_STEP)) ? POS_W'(SHIFT_STEP) : r_rem;

  // By PACK the magnitude is fully left-aligned, so the hidden one sits at the MSB.
  assign w_exp      = E_W'(EXP_BIAS + int'(r_pos) - FRAC_BITS);
  assign w_mant_raw = r_mag[DATA_W-2 -: SP_MANT_W];

`ifdef NORM_ROUND_EN
  logic                 w_guard;
  logic                 w_sticky;
  logic                 w_round_up;
  logic [SP_MANT_W:0]   w_mant_sum;

  assign w_guard    = r_mag[DATA_W-SP_MANT_W-2];
  assign w_sticky   = |r_mag[DATA_W-SP_MANT_W-3:0];
  assign w_round_up = w_guard & (w_sticky | w_mant_raw[0]);
  assign w_mant_sum = {1'b0, w_mant_raw} + {{SP_MANT_W{1'b0}}, w_round_up};
  // A carry out leaves the mantissa at zero and bumps the exponent.
  assign w_mant     = w_mant_sum[SP_MANT_W-1:0];
  assign w_exp_fin  = w_exp + $signed({{(E_W-1){1'b0}}, w_mant_sum[SP_MANT_W]});
`else
  assign w_mant     = w_mant_raw;
  assign w_exp_fin  = w_exp;
`endif

  assign w_pack = pack_sp(r_sign, r_zero, 32'(w_exp_fin), w_mant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_pos       <= '0;
      r_rem       <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_udf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign  <= in_sign;
            r_mag   <= in_mag;
            r_zero  <= 1'b0;
            r_state <= S_DETECT;
          end
        end
        S_DETECT: begin
          r_pos  <= w_lead_pos;
          r_rem  <= w_rem;
          r_zero <= w_lead_zero;
          if (w_lead_zero || (w_rem == '0)) r_state <= S_PACK;
          else                              r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_mag <= r_mag << w_shamt;
          r_rem <= r_rem - w_shamt;
          if (r_rem == w_shamt) r_state <= S_PACK;
        end
        S_PACK: begin
          r_out_data  <= w_pack.data;
          r_out_zero  <= w_pack.zero;
          r_out_ovf   <= w_pack.ovf;
          r_out_udf   <= w_pack.udf;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;
  assign out_ovf   = r_out_ovf;
  assign out_udf   = r_out_udf;

endmodule

// File: tb/tb_fxp_to_fp_norm_ctrl.sv
// Self-checking bench for fxp_to_fp_norm_ctrl: directed vector table, handshake/reset sequences, random vs model.
module tb_fxp_to_fp_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [31:0] in_mag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_ovf;
  logic        out_udf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fxp_to_fp_norm_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_udf   (out_udf)
  );

  typedef struct {
    logic        sign;
    logic [31:0] mag;
    logic [31:0] data;
    logic        zero;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: value = mag / 2^24, expressed as 1.f * 2^p with plain integer arithmetic.
  function automatic void model(input logic s, input logic [31:0] m,
                                output logic [31:0] d, output logic z, output int lat);
    longint unsigned mag, frac;
    int p, e;
`ifdef NORM_ROUND_EN
    longint unsigned rmd, half;
`endif
    if (m == 0) begin
      d = {s, 31'b0};
      z = 1'b1;
      lat = 3;
      return;
    end
    z = 1'b0;
    mag = m;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = 127 + p - 24;
    if (p <= 23) begin
      frac = mag << (23 - p);
    end else begin
      frac = mag >> (p - 23);
`ifdef NORM_ROUND_EN
      rmd  = mag - (frac << (p - 23));
      half = 64'd1 << (p - 24);
      if (rmd > half || (rmd == half && frac[0])) frac++;
      if (frac == (64'd1 << 24)) begin
        frac = 64'd1 << 23;
        e++;
      end
`endif
    end
    d = {s, 8'(e), 23'(frac - (64'd1 << 23))};
    lat = 3 + (31 - p + 7) / 8;
  endfunction

  // Presents one word, waits for out_valid; leaves the result unaccepted.
  task automatic run_txn(input logic s, input logic [31:0] m, output int lat, output bit ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = m;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      #1;
    end
    ok = out_valid;
  endtask

  task automatic accept_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_cleared"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic check_result(input string name, input logic [31:0] d, input logic z,
                              input int lat_req, input int lat, input bit ok);
    check({name, "_timeout"}, {31'b0, ok}, 32'd1);
    check({name, "_data"}, out_data, d);
    check({name, "_zero"}, {31'b0, out_zero}, {31'b0, z});
    check({name, "_ovf_udf"}, {30'b0, out_ovf, out_udf}, 32'd0);
    check({name, "_latency"}, 32'(lat), 32'(lat_req));
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] d0, exp_d, rm;
    logic        exp_z, rs;
    int          lat, exp_lat;
    bit          ok, seen;

    vecs[0] = '{1'b0, 32'h0100_0000, 32'h3F80_0000, 1'b0, 4};
    vecs[1] = '{1'b0, 32'h0000_0001, 32'h3380_0000, 1'b0, 7};
    vecs[2] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 1'b1, 3};
`ifdef NORM_ROUND_EN
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h4380_0000, 1'b0, 3};
`else
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'h437F_FFFF, 1'b0, 3};
`endif
    vecs[4] = '{1'b1, 32'h0100_0000, 32'hBF80_0000, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h00FF_FFFF, 32'h3F7F_FFFF, 1'b0, 4};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h4300_0000, 1'b0, 3};
    vecs[7] = '{1'b0, 32'h0000_0100, 32'h3780_0000, 1'b0, 6};

    rst = 1'b1;
    in_valid = 1'b0;
    in_sign = 1'b0;
    in_mag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_flags", {29'b0, out_zero, out_ovf, out_udf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].sign, vecs[i].mag, lat, ok);
      $display("vec %0d sign=%b mag=%h data=%h zero=%b lat=%0d", i, vecs[i].sign, vecs[i].mag,
               out_data, out_zero, lat);
      check_result($sformatf("vec%0d", i), vecs[i].data, vecs[i].zero, vecs[i].lat, lat, ok);
      accept_result($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold and new input must be ignored while OUT waits.
    run_txn(1'b0, 32'h0000_0001, lat, ok);
    check("bp_timeout", {31'b0, ok}, 32'd1);
    d0 = out_data;
    check("bp_first", d0, 32'h3380_0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_mag   = 32'h0100_0000;
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data_stable", out_data, d0);
      check("bp_flags_stable", {29'b0, out_zero, out_ovf, out_udf}, 32'd0);
    end
    in_valid = 1'b0;
    accept_result("bp");
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("bp_ignored_input", {31'b0, seen}, 32'd0);
    check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    $display("txn backpressure data=%h held 5 cycles", d0);

    // Asynchronous reset in the middle of SHIFT aborts the conversion.
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_mag   = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 32'h0100_0000, lat, ok);
    $display("txn after reset data=%h lat=%0d", out_data, lat);
    check_result("post_rst", 32'h3F80_0000, 1'b0, 4, lat, ok);
    accept_result("post_rst");

    for (int t = 0; t < 40; t++) begin
      rs = 1'($urandom_range(0, 1));
      rm = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) rm = '0;
      model(rs, rm, exp_d, exp_z, exp_lat);
      run_txn(rs, rm, lat, ok);
      $display("rnd %0d sign=%b mag=%h data=%h exp=%h lat=%0d", t, rs, rm, out_data, exp_d, lat);
      check_result($sformatf("rnd%0d", t), exp_d, exp_z, exp_lat, lat, ok);
      accept_result($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
